// File: rtl/fft8_pkg.sv
// Shared sample/frame types for the 8-point FFT input loader.
package fft8_pkg;
    localparam int DW = 22;
    localparam int N  = 8;
    localparam int IW = 3;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cpx_t;

    typedef cpx_t [N-1:0] frame_t;
endpackage

// File: rtl/fft8_bank.sv
// One frame bank: N complex slots with an indexed write port, a synchronous clear and flat outputs.
module fft8_bank
    import fft8_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            i_we,
    input  logic [IW-1:0]   i_idx,
    input  cpx_t            i_data,
    input  logic            i_clr,
    output logic [N*DW-1:0] o_re,
    output logic [N*DW-1:0] o_im
);
    frame_t r_slots;

    // Clearing on free guarantees short frames present zeros in their unwritten slots.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slots <= '0;
        end else if (i_clr) begin
            r_slots <= '0;
        end else if (i_we) begin
            r_slots[i_idx] <= i_data;
        end
    end

    always_comb begin
        o_re = '0;
        o_im = '0;
        for (int k = 0; k < N; k++) begin
            o_re[k*DW +: DW] = r_slots[k].re;
            o_im[k*DW +: DW] = r_slots[k].im;
        end
    end
endmodule

// File: rtl/fft8_frame_loader.sv
// Serial-to-frame loader: packs a sample stream into ping-pong banks and presents whole frames to the FFT core.
module fft8_frame_loader
    import fft8_pkg::*;
#(
    parameter int DW  = fft8_pkg::DW,
    parameter int N   = fft8_pkg::N,
    parameter int IDW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [DW-1:0]   s_re,
    input  logic [DW-1:0]   s_im,
    input  logic            s_last,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N*DW-1:0] m_re,
    output logic [N*DW-1:0] m_im,
    output logic [IDW-1:0]  m_frame_id,
    output logic            err_last
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends on valid.
    logic [1:0]     r_full;
    logic           r_wr_bank;
    logic           r_rd_bank;
    logic [IW-1:0]  r_wr_idx;
    logic [IDW-1:0] r_frame_cnt;
    logic [IDW-1:0] r_id [2];
    logic           r_err_last;

    logic            w_s_acc;
    logic            w_m_hs;
    logic            w_last_slot;
    logic            w_commit;
    logic [1:0]      w_we;
    logic [1:0]      w_clr;
    cpx_t            w_sample;
    logic [N*DW-1:0] w_re [2];
    logic [N*DW-1:0] w_im [2];

    assign s_ready     = !r_full[r_wr_bank];
    assign m_valid     = r_full[r_rd_bank];
    assign w_s_acc     = s_valid && s_ready;
    assign w_m_hs      = m_valid && m_ready;
    assign w_last_slot = (r_wr_idx == IW'(N-1));
    assign w_commit    = w_s_acc && (w_last_slot || s_last);
    assign w_sample.re = s_re;
    assign w_sample.im = s_im;

    always_comb begin
        w_we             = '0;
        w_clr            = '0;
        w_we[r_wr_bank]  = w_s_acc;
        w_clr[r_rd_bank] = w_m_hs;
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft8_bank u_bank (
            .clk    (clk),
            .rst    (rst),
            .i_we   (w_we[b]),
            .i_idx  (r_wr_idx),
            .i_data (w_sample),
            .i_clr  (w_clr[b]),
            .o_re   (w_re[b]),
            .o_im   (w_im[b])
        );
    end

    // Commit and free always target different banks, since full gates both sides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full      <= '0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_wr_idx    <= '0;
            r_frame_cnt <= '0;
            r_id[0]     <= '0;
            r_id[1]     <= '0;
            r_err_last  <= 1'b0;
        end else begin
            if (w_commit) begin
                r_full[r_wr_bank] <= 1'b1;
                r_id[r_wr_bank]   <= r_frame_cnt;
                r_frame_cnt       <= r_frame_cnt + 1'b1;
                r_wr_idx          <= '0;
                r_wr_bank         <= ~r_wr_bank;
            end else if (w_s_acc) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
            if (w_m_hs) begin
                r_full[r_rd_bank] <= 1'b0;
                r_rd_bank         <= ~r_rd_bank;
            end
            r_err_last <= w_s_acc && (w_last_slot != s_last);
        end
    end

    assign m_re       = w_re[r_rd_bank];
    assign m_im       = w_im[r_rd_bank];
    assign m_frame_id = r_id[r_rd_bank];
    assign err_last   = r_err_last;
endmodule

// File: tb/tb_fft8_frame_loader.sv
// Directed and randomized bench for fft8_frame_loader against a frame-level reference model.
module tb_fft8_frame_loader;
    localparam int DW  = 22;
    localparam int N   = 8;
    localparam int IDW = 8;
    localparam int W   = IDW + 2*N*DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_valid = 1'b0;
    logic            s_ready;
    logic [DW-1:0]   s_re = '0;
    logic [DW-1:0]   s_im = '0;
    logic            s_last = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [N*DW-1:0] m_re;
    logic [N*DW-1:0] m_im;
    logic [IDW-1:0]  m_frame_id;
    logic            err_last;

    always #5 clk = ~clk;

    fft8_frame_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_re       (s_re),
        .s_im       (s_im),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_frame_id (m_frame_id),
        .err_last   (err_last)
    );

    // Reference model: frames awaiting consumption as {id, im, re}, plus the frame being assembled.
    logic [W-1:0]   exp_q [$];
    logic [DW-1:0]  b_re [N];
    logic [DW-1:0]  b_im [N];
    int             b_cnt;
    int             pending;
    logic [IDW-1:0] m_cnt;
    logic           err_exp;
    int             checks = 0;
    int             errors = 0;
    int             frames_seen;
    int             err_seen;
    int             valid_cycles;
    int             ready_low;
    logic [IDW-1:0] last_id;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic         exp_ready;
        logic         exp_mvalid;
        logic         new_err;
        logic [W-1:0] f;
        if (rst) begin
            exp_q.delete();
            b_cnt = 0;
            pending = 0;
            m_cnt = '0;
            err_exp = 1'b0;
            frames_seen = 0;
            err_seen = 0;
            valid_cycles = 0;
            ready_low = 0;
            last_id = '1;
            for (int k = 0; k < N; k++) begin
                b_re[k] = '0;
                b_im[k] = '0;
            end
        end else begin
            exp_ready  = (pending < 2);
            exp_mvalid = (pending > 0);
            check("s_ready", W'(s_ready), W'(exp_ready));
            check("m_valid", W'(m_valid), W'(exp_mvalid));
            check("err_last", W'(err_last), W'(err_exp));
            if (err_last) err_seen++;
            if (m_valid) valid_cycles++;
            if (!s_ready) ready_low++;
            new_err = 1'b0;
            if (exp_mvalid && exp_q.size() > 0) begin
                f = exp_q[0];
                check("m_re", W'(m_re), W'(f[N*DW-1:0]));
                check("m_im", W'(m_im), W'(f[2*N*DW-1:N*DW]));
                check("m_frame_id", W'(m_frame_id), W'(f[W-1 -: IDW]));
                if (m_ready) begin
                    last_id = m_frame_id;
                    void'(exp_q.pop_front());
                    pending--;
                    frames_seen++;
                end
            end
            if (s_valid && exp_ready) begin
                b_re[b_cnt] = s_re;
                b_im[b_cnt] = s_im;
                if (b_cnt == N-1 || s_last) begin
                    new_err = ((b_cnt == N-1) != s_last);
                    f = '0;
                    for (int k = 0; k < N; k++) begin
                        f[k*DW +: DW]        = b_re[k];
                        f[N*DW + k*DW +: DW] = b_im[k];
                        b_re[k] = '0;
                        b_im[k] = '0;
                    end
                    f[W-1 -: IDW] = m_cnt;
                    exp_q.push_back(f);
                    m_cnt++;
                    pending++;
                    b_cnt = 0;
                end else begin
                    b_cnt++;
                end
            end
            err_exp = new_err;
        end
    end

    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        int waitc;
        waitc = 0;
        s_valid = 1'b1;
        s_re = re;
        s_im = im;
        s_last = last;
        @(negedge clk);
        while (!s_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        check("send_timeout", W'(waitc < 200), W'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        s_last = 1'b0;
        m_ready = 1'b0;
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset values while rst is held.
        repeat (2) @(negedge clk);
        check("rst_s_ready", W'(s_ready), W'(1));
        check("rst_m_valid", W'(m_valid), W'(0));
        check("rst_m_re", W'(m_re), W'(0));
        check("rst_m_im", W'(m_im), W'(0));
        check("rst_m_frame_id", W'(m_frame_id), W'(0));
        check("rst_err_last", W'(err_last), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame of (k, -k).
        m_ready = 1'b1;
        for (int k = 0; k < N; k++) send(DW'(k), DW'(-k), k == N-1);
        idle(4);
        check("single_frames", W'(frames_seen), W'(1));
        check("single_valid_cycles", W'(valid_cycles), W'(1));
        check("single_err", W'(err_seen), W'(0));
        check("single_id", W'(last_id), W'(0));

        // Streaming 32 samples with the consumer always ready.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 32; i++) send(DW'($urandom()), DW'($urandom()), (i % N) == N-1);
        idle(4);
        check("stream_frames", W'(frames_seen), W'(4));
        check("stream_ready_low", W'(ready_low), W'(0));
        check("stream_err", W'(err_seen), W'(0));
        check("stream_last_id", W'(last_id), W'(3));

        // Backpressure: both banks fill, then one read frees a bank.
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(DW'($urandom()), DW'($urandom()), (i % N) == N-1);
        s_valid = 1'b1;
        s_re = DW'($urandom());
        s_im = DW'($urandom());
        s_last = 1'b0;
        @(negedge clk);
        check("bp_s_ready_low", W'(s_ready), W'(0));
        check("bp_held_id", W'(m_frame_id), W'(0));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        @(negedge clk);
        check("bp_s_ready_back", W'(s_ready), W'(1));
        check("bp_next_id", W'(m_frame_id), W'(1));
        check("bp_next_valid", W'(m_valid), W'(1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int i = 17; i < 24; i++) send(DW'($urandom()), DW'($urandom()), i == 23);
        m_ready = 1'b1;
        idle(4);
        check("bp_frames", W'(frames_seen), W'(3));
        check("bp_err", W'(err_seen), W'(0));

        // Early s_last on the 5th sample, then a normal frame.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(DW'($urandom()), DW'($urandom()), i == 4);
        for (int i = 0; i < N; i++) send(DW'($urandom()), DW'($urandom()), i == N-1);
        idle(4);
        check("early_err", W'(err_seen), W'(1));
        check("early_frames", W'(frames_seen), W'(2));

        // Eight samples without s_last.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) send(DW'($urandom()), DW'($urandom()), 1'b0);
        idle(4);
        check("missing_err", W'(err_seen), W'(1));
        check("missing_frames", W'(frames_seen), W'(1));

        // Reset after three samples discards the partial frame.
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(DW'($urandom()), DW'($urandom()), 1'b0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < N; i++) send(DW'($urandom()), DW'($urandom()), i == N-1);
        idle(4);
        check("midrst_frames", W'(frames_seen), W'(1));
        check("midrst_id", W'(last_id), W'(0));
        check("midrst_err", W'(err_seen), W'(0));

        // Random traffic on both sides, with occasional stray s_last.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_re    = DW'($urandom());
            s_im    = DW'($urandom());
            s_last  = ($urandom_range(0, 9) == 0);
            m_ready = ($urandom_range(0, 9) < 6);
            idle(1);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        idle(6);
        @(negedge clk);
        check("rand_drained_valid", W'(m_valid), W'(0));
        check("rand_drained_ready", W'(s_ready), W'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
